// File: rtl/hpdcache_mem_read_credit.sv
// ============================================================================
// Module   : hpdcache_mem_read_credit
// Brief    : Credit-based read-channel regulator. Requests are forwarded only
//            when a response slot is reserved; responses drain through a FIFO.
//            Optional macro HPDCACHE_MEM_READ_CREDIT_BYPASS_EN enables a
//            0-cycle response bypass when the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hpdcache_mem_read_credit #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned REQ_WIDTH = 68,
    parameter int unsigned RSP_WIDTH = 520
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cache_req_valid_i,
    output logic                         cache_req_ready_o,
    input  logic [REQ_WIDTH-1:0]         cache_req_i,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic [REQ_WIDTH-1:0]         mem_req_o,
    input  logic                         mem_rsp_valid_i,
    output logic                         mem_rsp_ready_o,
    input  logic [RSP_WIDTH-1:0]         mem_rsp_i,
    output logic                         cache_rsp_valid_o,
    input  logic                         cache_rsp_ready_i,
    output logic [RSP_WIDTH-1:0]         cache_rsp_o,
    output logic [$clog2(DEPTH+1)-1:0]   credits_o,
    output logic                         idle_o,
    output logic                         err_o
);

    localparam int unsigned           c_cnt_w    = $clog2(DEPTH + 1);
    localparam int unsigned           c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cnt_w-1:0]    c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_ptr_w-1:0]    c_last_ptr = c_ptr_w'(DEPTH - 1);

    logic [c_cnt_w-1:0]   out_q, out_d;
    logic [c_cnt_w-1:0]   occ_q, occ_d;
    logic [c_ptr_w-1:0]   wptr_q, wptr_d;
    logic [c_ptr_w-1:0]   rptr_q, rptr_d;
    logic                 err_q, err_d;
    logic [RSP_WIDTH-1:0] fifo_q [DEPTH];
    logic [RSP_WIDTH-1:0] fifo_d [DEPTH];

    logic [c_cnt_w-1:0]   credits;
    logic                 has_credit;
    logic                 req_hs;
    logic                 rsp_acc;
    logic                 rsp_expected;
    logic                 bypass;
    logic                 push;
    logic                 pop;

    // Pointers wrap modulo DEPTH; with DEPTH=1 they stay at zero.
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign credits    = c_depth - out_q - occ_q;
    assign has_credit = (credits != '0);

    assign mem_req_valid_o   = cache_req_valid_i & has_credit;
    assign cache_req_ready_o = mem_req_ready_i & has_credit;
    assign mem_req_o         = cache_req_i;
    assign req_hs            = mem_req_valid_o & mem_req_ready_i;

    assign mem_rsp_ready_o = (occ_q < c_depth);
    assign rsp_acc         = mem_rsp_valid_i & mem_rsp_ready_o;
    assign rsp_expected    = rsp_acc & (out_q != '0);

`ifdef HPDCACHE_MEM_READ_CREDIT_BYPASS_EN
    assign bypass            = rsp_expected & (occ_q == '0) & cache_rsp_ready_i;
    assign cache_rsp_valid_o = (occ_q != '0) | (mem_rsp_valid_i & (out_q != '0));
    assign cache_rsp_o       = (occ_q != '0) ? fifo_q[rptr_q] : mem_rsp_i;
`else
    assign bypass            = 1'b0;
    assign cache_rsp_valid_o = (occ_q != '0);
    assign cache_rsp_o       = fifo_q[rptr_q];
`endif

    assign push = rsp_expected & ~bypass;
    assign pop  = (occ_q != '0) & cache_rsp_ready_i;

    assign credits_o = credits;
    assign idle_o    = (out_q == '0) & (occ_q == '0);
    assign err_o     = err_q;

    always_comb begin
        out_d  = out_q + c_cnt_w'(req_hs) - c_cnt_w'(rsp_expected);
        occ_d  = occ_q + c_cnt_w'(push) - c_cnt_w'(pop);
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        // A beat with nothing outstanding is dropped and flagged.
        err_d  = err_q | (rsp_acc & (out_q == '0));
    end

    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wptr_q] = mem_rsp_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q  <= '0;
            occ_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            occ_q  <= occ_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            err_q  <= err_d;
        end
    end

    // Payload storage needs no reset: occupancy qualifies every read.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

`ifndef SYNTHESIS
    a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        (32'(out_q) + 32'(occ_q)) <= DEPTH);
    a_rsp_ready: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rsp_valid_i |-> mem_rsp_ready_o);
    a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (cache_req_valid_i && !cache_req_ready_o) |=> (!cache_req_valid_i || $stable(cache_req_i)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_hpdcache_mem_read_credit.sv
// ============================================================================
// Module   : tb_hpdcache_mem_read_credit
// Brief    : Self-checking bench: cycle table plus directed corner sequences,
//            response payloads checked through scoreboard queues.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hpdcache_mem_read_credit;

`ifdef HPDCACHE_MEM_READ_CREDIT_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;

    // DEPTH=4 instance
    logic         cache_req_valid_i = 1'b0;
    logic         cache_req_ready_o;
    logic [67:0]  cache_req_i = '0;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic [67:0]  mem_req_o;
    logic         mem_rsp_valid_i = 1'b0;
    logic         mem_rsp_ready_o;
    logic [519:0] mem_rsp_i = '0;
    logic         cache_rsp_valid_o;
    logic         cache_rsp_ready_i = 1'b0;
    logic [519:0] cache_rsp_o;
    logic [2:0]   credits_o;
    logic         idle_o;
    logic         err_o;

    // DEPTH=1 instance
    logic         d1_req_valid = 1'b0;
    logic         d1_req_ready;
    logic [7:0]   d1_req = '0;
    logic         d1_mreq_valid;
    logic         d1_mreq_ready = 1'b0;
    logic [7:0]   d1_mreq;
    logic         d1_mrsp_valid = 1'b0;
    logic         d1_mrsp_ready;
    logic [7:0]   d1_mrsp = '0;
    logic         d1_rsp_valid;
    logic         d1_rsp_ready = 1'b0;
    logic [7:0]   d1_rsp;
    logic [0:0]   d1_credits;
    logic         d1_idle;
    logic         d1_err;

    hpdcache_mem_read_credit #(.DEPTH(4), .REQ_WIDTH(68), .RSP_WIDTH(520)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cache_req_valid_i(cache_req_valid_i), .cache_req_ready_o(cache_req_ready_o),
        .cache_req_i(cache_req_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_o(mem_req_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .mem_rsp_i(mem_rsp_i),
        .cache_rsp_valid_o(cache_rsp_valid_o), .cache_rsp_ready_i(cache_rsp_ready_i),
        .cache_rsp_o(cache_rsp_o),
        .credits_o(credits_o), .idle_o(idle_o), .err_o(err_o)
    );

    hpdcache_mem_read_credit #(.DEPTH(1), .REQ_WIDTH(8), .RSP_WIDTH(8)) u_dut_d1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .cache_req_valid_i(d1_req_valid), .cache_req_ready_o(d1_req_ready),
        .cache_req_i(d1_req),
        .mem_req_valid_o(d1_mreq_valid), .mem_req_ready_i(d1_mreq_ready),
        .mem_req_o(d1_mreq),
        .mem_rsp_valid_i(d1_mrsp_valid), .mem_rsp_ready_o(d1_mrsp_ready),
        .mem_rsp_i(d1_mrsp),
        .cache_rsp_valid_o(d1_rsp_valid), .cache_rsp_ready_i(d1_rsp_ready),
        .cache_rsp_o(d1_rsp),
        .credits_o(d1_credits), .idle_o(d1_idle), .err_o(d1_err)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int n_hs     = 0;
    int d1_rx    = 0;
    logic [519:0] q4 [$];
    logic [7:0]   q1 [$];

    task automatic chk(input string nm, input logic [519:0] act, input logic [519:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Sample the request handshake just before the edge, then step one cycle.
    task automatic tick();
        bit hs;
        #1;
        hs = cache_req_valid_i && cache_req_ready_o;
        @(posedge clk_i);
        #1;
        if (hs) begin
            n_hs++;
            cache_req_i = cache_req_i + 68'd1;
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && cache_rsp_valid_o && cache_rsp_ready_i) begin
            if (q4.size() == 0) chk("rsp_extra", cache_rsp_o, '0);
            else                chk("rsp_data", cache_rsp_o, q4.pop_front());
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i && d1_rsp_valid && d1_rsp_ready) begin
            d1_rx++;
            if (q1.size() == 0) chk("d1_rsp_extra", 520'(d1_rsp), '1);
            else                chk("d1_rsp_data", 520'(d1_rsp), 520'(q1.pop_front()));
        end
    end

    typedef struct {
        int rv; int mr; int sv; int sd; int cr;
        int e_cred; int e_idle; int e_mrv; int e_crr; int e_rsv;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // single request, response three cycles later
        vecs[0]  = '{1, 1, 0, 0,     1, 4, 1, 1, 1, 0};
        vecs[1]  = '{0, 1, 0, 0,     1, 3, 0, 0, 1, 0};
        vecs[2]  = '{0, 1, 0, 0,     1, 3, 0, 0, 1, 0};
        vecs[3]  = '{0, 1, 1, 'hA5,  1, 3, 0, 0, 1, BYP};
        vecs[4]  = '{0, 1, 0, 0,     1, BYP ? 4 : 3, BYP, 0, 1, 1 - BYP};
        vecs[5]  = '{0, 1, 0, 0,     1, 4, 1, 0, 1, 0};
        // request valid independent of fabric ready
        vecs[6]  = '{1, 0, 0, 0,     1, 4, 1, 1, 0, 0};
        // same-cycle handshake, push and pop at out=1, occ=1
        vecs[7]  = '{1, 1, 0, 0,     0, 4, 1, 1, 1, 0};
        vecs[8]  = '{1, 1, 0, 0,     0, 3, 0, 1, 1, 0};
        vecs[9]  = '{0, 1, 1, 1,     0, 2, 0, 0, 1, BYP};
        vecs[10] = '{1, 1, 1, 2,     1, 2, 0, 1, 1, 1};
        vecs[11] = '{0, 1, 1, 3,     1, 2, 0, 0, 1, 1};
        vecs[12] = '{0, 1, 0, 0,     1, 3, 0, 0, 1, 1};
        vecs[13] = '{0, 1, 0, 0,     1, 4, 1, 0, 1, 0};

        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_credits", 520'(credits_o), 4);
        chk("rst_idle", 520'(idle_o), 1);
        chk("rst_err", 520'(err_o), 0);
        chk("rst_rsp_valid", 520'(cache_rsp_valid_o), 0);
        chk("rst_mrsp_ready", 520'(mem_rsp_ready_o), 1);
        chk("rst_mreq_valid", 520'(mem_req_valid_o), 0);
        chk("rst_d1_credits", 520'(d1_credits), 1);
        rst_i = 1'b0;

        for (int i = 0; i < 14; i++) begin
            cache_req_valid_i = vecs[i].rv[0];
            mem_req_ready_i   = vecs[i].mr[0];
            mem_rsp_valid_i   = vecs[i].sv[0];
            mem_rsp_i         = 520'(vecs[i].sd);
            cache_rsp_ready_i = vecs[i].cr[0];
            if (vecs[i].sv != 0) q4.push_back(520'(vecs[i].sd));
            #1;
            chk($sformatf("v%0d_credits", i), 520'(credits_o), 520'(vecs[i].e_cred));
            chk($sformatf("v%0d_idle", i), 520'(idle_o), 520'(vecs[i].e_idle));
            chk($sformatf("v%0d_mreq_valid", i), 520'(mem_req_valid_o), 520'(vecs[i].e_mrv));
            chk($sformatf("v%0d_creq_ready", i), 520'(cache_req_ready_o), 520'(vecs[i].e_crr));
            chk($sformatf("v%0d_rsp_valid", i), 520'(cache_rsp_valid_o), 520'(vecs[i].e_rsv));
            chk($sformatf("v%0d_mreq_data", i), 520'(mem_req_o), 520'(cache_req_i));
            tick();
        end
        cache_req_valid_i = 1'b0;
        mem_rsp_valid_i   = 1'b0;

        // credit exhaustion with the cache stalled
        cache_rsp_ready_i = 1'b0;
        mem_req_ready_i   = 1'b1;
        cache_req_valid_i = 1'b1;
        n_hs = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 3) chk("exh_ready_c3", 520'(cache_req_ready_o), 1);
            if (c == 4) chk("exh_ready_c4", 520'(cache_req_ready_o), 0);
            if (c == 5) chk("exh_mreq_valid_c5", 520'(mem_req_valid_o), 0);
            tick();
        end
        cache_req_valid_i = 1'b0;
        chk("exh_handshakes", 520'(n_hs), 4);
        chk("exh_credits", 520'(credits_o), 0);
        for (int k = 0; k < 4; k++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_i       = 520'(16 + k);
            q4.push_back(520'(16 + k));
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("full_credits", 520'(credits_o), 0);
        chk("full_rsp_valid", 520'(cache_rsp_valid_o), 1);
        cache_rsp_ready_i = 1'b1;
        cache_req_valid_i = 1'b1;
        #1;
        chk("pop_cycle_ready", 520'(cache_req_ready_o), 0);
        tick();
        #1;
        chk("after_pop_credits", 520'(credits_o), 1);
        chk("after_pop_ready", 520'(cache_req_ready_o), 1);
        tick();
        cache_req_valid_i = 1'b0;
        mem_rsp_valid_i   = 1'b1;
        mem_rsp_i         = 520'(20);
        q4.push_back(520'(20));
        tick();
        mem_rsp_valid_i = 1'b0;
        for (int k = 0; k < 20 && !idle_o; k++) tick();
        chk("drain_idle", 520'(idle_o), 1);
        chk("drain_credits", 520'(credits_o), 4);
        chk("drain_queue_empty", 520'(q4.size()), 0);

        // unexpected response
        mem_rsp_valid_i = 1'b1;
        mem_rsp_i       = 520'('hEE);
        #1;
        chk("unexp_rsp_valid", 520'(cache_rsp_valid_o), 0);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("unexp_err", 520'(err_o), 1);
        chk("unexp_rsp_valid_after", 520'(cache_rsp_valid_o), 0);
        chk("unexp_credits", 520'(credits_o), 4);
        repeat (3) tick();
        chk("unexp_err_sticky", 520'(err_o), 1);

        // asynchronous reset with out=2, occ=1
        cache_rsp_ready_i = 1'b0;
        cache_req_valid_i = 1'b1;
        repeat (3) tick();
        cache_req_valid_i = 1'b0;
        mem_rsp_valid_i   = 1'b1;
        mem_rsp_i         = 520'('h30);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("pre_rst_credits", 520'(credits_o), 1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("arst_credits", 520'(credits_o), 4);
        chk("arst_rsp_valid", 520'(cache_rsp_valid_o), 0);
        chk("arst_idle", 520'(idle_o), 1);
        chk("arst_err", 520'(err_o), 0);
        chk("arst_mrsp_ready", 520'(mem_rsp_ready_o), 1);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_i       = 520'('h40);
        tick();
        mem_rsp_valid_i = 1'b0;
        #1;
        chk("stray_err", 520'(err_o), 1);
        chk("stray_rsp_valid", 520'(cache_rsp_valid_o), 0);

        // DEPTH=1 alternating request/response
        d1_mreq_ready = 1'b1;
        d1_rsp_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d1_req_valid = 1'b1;
            d1_req       = 8'(i);
            #1;
            chk($sformatf("d1_it%0d_credits_1", i), 520'(d1_credits), 1);
            chk($sformatf("d1_it%0d_ready", i), 520'(d1_req_ready), 1);
            tick();
            d1_req_valid  = 1'b0;
            d1_mrsp_valid = 1'b1;
            d1_mrsp       = 8'(i);
            q1.push_back(8'(i));
            #1;
            chk($sformatf("d1_it%0d_credits_0", i), 520'(d1_credits), 0);
            tick();
            d1_mrsp_valid = 1'b0;
            #1;
            chk($sformatf("d1_it%0d_rsp_valid", i), 520'(d1_rsp_valid), 520'(1 - BYP));
            tick();
        end
        #1;
        chk("d1_rx_count", 520'(d1_rx), 8);
        chk("d1_queue_empty", 520'(q1.size()), 0);
        chk("d1_idle", 520'(d1_idle), 1);
        chk("d1_err", 520'(d1_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
